pattern_tx: RTL and testbench
=============================

PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 Parameter WIDTH, default 16: maximum pattern length in bits.
REQ-002 Parameter GAP, default 2: idle bit-times inserted between repetitions.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (reset=0 resets).
REQ-005 start  input  1  request to transmit; sampled only in IDLE.
REQ-006 pattern  input  WIDTH  bits to send; captured on an accepted start.
REQ-007 len  input  $clog2(WIDTH)+1  number of bits to send; captured on an accepted start.
REQ-008 reps  input  4  number of transmissions; 0 is treated as 1.
REQ-009 abort  input  1  synchronous cancel of any transfer in progress.
REQ-010 x  output  1  serial bit stream, registered; feeds a serial sequence detector's x input.
REQ-011 valid  output  1  high while x carries a pattern bit.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse after the final bit of the final repetition.

Function
REQ-014 States: IDLE, SHIFT, GAP_ST, DONE; encoding is implementation-defined.
REQ-015 IDLE -> SHIFT: start=1 and len!=0 at a clock edge.
- Same edge: capture pattern, len and reps (len above WIDTH is clamped to WIDTH).
- Load the bit counter with the captured len.
REQ-016 start with len=0 is ignored; the block stays in IDLE and done does not pulse.
REQ-017 Bit order is MSB-first: the first bit is pattern[len-1] and the last is pattern[0].
REQ-018 Latency: the first bit appears on x with valid=1 in the cycle after the accepting edge.
- One bit per clock; no bubbles within a repetition.
REQ-019 After the last bit of a repetition:
- Repetitions remaining: go to GAP_ST for exactly GAP cycles with x=0 and valid=0, then re-enter SHIFT from the captured pattern.
- GAP=0: the repetitions are back-to-back with no idle cycles.
REQ-020 After the last bit of the last repetition: go to DONE for one cycle (done=1, x=0, valid=0), then return to IDLE.
REQ-021 start while busy=1 is ignored; captured values do not change mid-transfer.
REQ-022 abort=1 in any non-IDLE state:
- Next state is IDLE with x=0, valid=0, busy=0.
- done does not pulse.
- abort has priority over all other transitions.
REQ-023 abort and start both asserted in IDLE: start wins, since abort has no effect in IDLE.
REQ-024 start sampled in the same cycle as the DONE state is ignored; a new transfer is accepted no earlier than the following IDLE cycle.
REQ-025 Counter widths hold WIDTH and GAP without overflow; the repetition counter is 4 bits and counts down to 1.

Reset
REQ-026 reset=0 asynchronously forces:
- State IDLE.
- x=0, valid=0, busy=0, done=0.
- All counters and capture registers to 0.
REQ-027 Reset asserted mid-transfer aborts immediately with no done pulse.
- The first edge after release sees the block in IDLE, ready to accept start.

Structure
REQ-028 State enumeration and default WIDTH/GAP values reside in a shared package, pattern_pkg, which the detector bench also imports.
REQ-029 The shift register is an optional sub-module, piso_shift (parallel load, MSB-first shift, WIDTH parameter).
- The FSM, counters and handshake logic stay in pattern_tx.

Verification
REQ-030 pattern=16'h000B, len=4, reps=1: x=1,0,1,1 with valid=1 in cycles 1-4 after start; done=1 in cycle 5; busy=0 in cycle 6.
REQ-031 pattern=16'h000B, len=4, reps=3, GAP=2: three "1011" bursts, each separated by 2 cycles of valid=0; a single done pulse at cycle 17.
REQ-032 start with len=0: busy stays 0 and done never pulses.
- start with len=20: the clamp to 16 gives exactly 16 bits with valid=1.
REQ-033 abort asserted during the 3rd bit: valid=0 and busy=0 on the next cycle, no done pulse; a fresh start is then accepted normally.
REQ-034 reset=0 held for 1 cycle mid-burst: outputs clear asynchronously before the next edge; a start issued after release produces a complete, correct burst.
REQ-035 End-to-end: pattern_tx output drives the team's sequence detector FSM with a "1011"-containing stream; detector output z is checked against a software model for every cycle.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern transmitter and the detector bench that consumes its stream.
package pattern_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_GAP   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        GAP_ST = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shifter: MSB is the current output bit, zeros enter at the LSB.
module piso_shift #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] sr_q, sr_d;

    // Next contents: clear beats load beats shift; otherwise hold.
    always_comb begin
        sr_d = sr_q;
        if (clear_i) begin
            sr_d = '0;
        end else if (load_i) begin
            sr_d = din_i;
        end else if (shift_i) begin
            sr_d = sr_q << 1;
        end
    end

    // Shift register storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends len bits of a captured pattern MSB-first,
// repeated reps times with GAP idle bit-times between repetitions, then pulses done.
module pattern_tx
    import pattern_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GAP   = DEF_GAP
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WIDTH-1:0]       pattern,
    input  logic [$clog2(WIDTH):0] len,
    input  logic [3:0]             reps,
    input  logic                   abort,
    output logic                   x,
    output logic                   valid,
    output logic                   busy,
    output logic                   done
);

    localparam int LW = $clog2(WIDTH) + 1;
    localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LW-1:0]    len_q, len_d;
    logic [3:0]       rep_q, rep_d;
    logic [LW-1:0]    bit_q, bit_d;
    logic [GW-1:0]    gap_q, gap_d;

    logic             sh_clear, sh_load, sh_shift;
    logic [WIDTH-1:0] sh_din;

    // Lengths beyond the register width are sent as the full width.
    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
        return (int'(l) > WIDTH) ? LW'(WIDTH) : l;
    endfunction

    // Left-justify the low l bits so the first bit to send sits at the MSB and
    // the shifter naturally drains to all-zero after the last bit.
    function automatic logic [WIDTH-1:0] align_msb(input logic [WIDTH-1:0] p,
                                                   input logic [LW-1:0]    l);
        return p << (WIDTH - int'(l));
    endfunction

    // Next-state, counter and shifter control; abort outranks every other transition.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        len_d    = len_q;
        rep_d    = rep_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        sh_clear = 1'b0;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_din   = align_msb(pat_q, len_q);

        if (abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            sh_clear = 1'b1;
            pat_d    = '0;
            len_d    = '0;
            rep_d    = '0;
            bit_d    = '0;
            gap_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (len != '0)) begin
                        len_d   = clamp_len(len);
                        pat_d   = pattern;
                        rep_d   = (reps == 4'd0) ? 4'd1 : reps;
                        bit_d   = len_d;
                        sh_load = 1'b1;
                        sh_din  = align_msb(pattern, len_d);
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_q > LW'(1)) begin
                        bit_d    = bit_q - LW'(1);
                        sh_shift = 1'b1;
                    end else if (rep_q > 4'd1) begin
                        rep_d = rep_q - 4'd1;
                        if (GAP == 0) begin
                            sh_load = 1'b1;
                            bit_d   = len_q;
                        end else begin
                            sh_shift = 1'b1;
                            gap_d    = GW'(GAP);
                            state_d  = GAP_ST;
                        end
                    end else begin
                        sh_shift = 1'b1;
                        rep_d    = '0;
                        bit_d    = '0;
                        state_d  = DONE;
                    end
                end
                GAP_ST: begin
                    if (gap_q > GW'(1)) begin
                        gap_d = gap_q - GW'(1);
                    end else begin
                        gap_d   = '0;
                        sh_load = 1'b1;
                        bit_d   = len_q;
                        state_d = SHIFT;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, capture and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
        end
    end

    piso_shift #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk     (clk),
        .reset   (reset),
        .clear_i (sh_clear),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .din_i   (sh_din),
        .msb_o   (x)
    );

    assign valid = (state_q == SHIFT);
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: an output-level reference model plus
// directed scenarios with literal expectations.
module tb_pattern_tx;

    localparam int W  = 16;
    localparam int GP = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [W-1:0]        pattern;
    logic [$clog2(W):0]  len;
    logic [3:0]          reps;
    logic                abort;
    logic                x, valid, busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    pattern_tx #(
        .WIDTH (W),
        .GAP   (GP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .reps    (reps),
        .abort   (abort),
        .x       (x),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of per-cycle output vectors {x,valid,busy,done}.
    logic [3:0] q[$];
    logic [3:0] cur = 4'b0000;

    task automatic push_burst(input logic [W-1:0] p, input int l, input int r);
        int n;
        int rr;
        n  = (l > W) ? W : l;
        rr = (r == 0) ? 1 : r;
        for (int k = 0; k < rr; k++) begin
            for (int i = n - 1; i >= 0; i--) q.push_back({p[i], 3'b110});
            if (k < rr - 1)
                for (int g = 0; g < GP; g++) q.push_back(4'b0010);
        end
        q.push_back(4'b0011);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            cur = 4'b0000;
        end else begin
            if (cur[1]) begin
                if (abort) q.delete();
            end else if (start && (len != 0)) begin
                push_burst(pattern, int'(len), int'(reps));
            end
            cur = (q.size() > 0) ? q.pop_front() : 4'b0000;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if ({x, valid, busy, done} !== cur) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t got {x,valid,busy,done}=%b want %b", $time, {x, valid, busy, done}, cur);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [W-1:0] p, input logic [$clog2(W):0] l, input logic [3:0] r);
        @(negedge clk);
        pattern = p;
        len     = l;
        reps    = r;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [3:0]  e1 [6];
    logic [16:0] vtrace, dtrace;
    int          cnt;

    initial begin
        e1 = '{4'b1110, 4'b0110, 4'b1110, 4'b1110, 4'b0011, 4'b0000};
        start = 0; abort = 0; pattern = '0; len = '0; reps = '0; reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {28'd0, x, valid, busy, done}, 32'h0);
        reset  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Single 1011 burst, cycle-exact.
        launch(16'h000B, 4, 1);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("single_c%0d", k + 1), {28'd0, x, valid, busy, done}, {28'd0, e1[k]});
        end
        repeat (2) @(negedge clk);

        // Three repetitions with gaps; done only at cycle 17.
        launch(16'h000B, 4, 3);
        vtrace = '0; dtrace = '0;
        for (int k = 1; k <= 17; k++) begin
            if (k > 1) @(negedge clk);
            vtrace = {vtrace[15:0], valid};
            dtrace = {dtrace[15:0], done};
        end
        check("reps3_valid", {15'd0, vtrace}, {15'd0, 17'b11110011110011110});
        check("reps3_done",  {15'd0, dtrace}, {15'd0, 17'b00000000000000001});
        repeat (3) @(negedge clk);

        // len=0 is ignored.
        launch(16'hFFFF, 0, 2);
        check("len0_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("len0_done", {31'd0, done}, 32'd0);

        // len=20 clamps to 16 bits.
        launch(16'hC3A5, 20, 1);
        cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (valid) cnt++;
        end
        check("len20_bits", cnt, 16);
        repeat (2) @(negedge clk);

        // Abort during the third bit, then a fresh transfer.
        launch(16'h000B, 4, 1);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_clear", {29'd0, valid, busy, done}, 32'd0);
        repeat (4) @(negedge clk);
        launch(16'h0006, 3, 2);
        repeat (12) @(negedge clk);

        // Start and abort together in IDLE: start wins.
        @(negedge clk);
        pattern = 16'h0005; len = 3; reps = 1; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", {29'd0, x, valid, busy}, 32'b111);
        repeat (6) @(negedge clk);

        // Start while busy is ignored; captured pattern does not change.
        launch(16'h0009, 4, 2);
        @(negedge clk);
        pattern = 16'hFFFF; len = 8; reps = 4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);

        // Start during the DONE cycle is ignored.
        launch(16'h000B, 4, 1);
        repeat (4) @(negedge clk);
        check("done_cycle", {31'd0, done}, 32'd1);
        pattern = 16'h000F; len = 4; reps = 1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_ignored", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);

        // reps=0 behaves as one repetition; full-width and 1-bit patterns.
        launch(16'h0003, 2, 0);
        repeat (5) @(negedge clk);
        launch(16'hA5C3, 16, 2);
        repeat (38) @(negedge clk);
        launch(16'h0001, 1, 3);
        repeat (12) @(negedge clk);

        // Abort inside a gap.
        launch(16'h000D, 4, 3);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_gap", {30'd0, busy, done}, 32'd0);
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-burst, then a complete burst.
        launch(16'h00F5, 8, 2);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check("async_reset_clear", {28'd0, x, valid, busy, done}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        launch(16'h000B, 4, 1);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("post_reset_c%0d", k + 1), {28'd0, x, valid, busy, done}, {28'd0, e1[k]});
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
